// File: rtl/crc_pkg.sv
// Shared presets and FSM state encoding for the framed CRC engine.
package crc_pkg;

    // Common CRC presets
    localparam logic [7:0]  CRC8_POLY           = 8'h07;
    localparam logic [7:0]  CRC8_LEGACY_RESIDUE = 8'hAC;
    localparam logic [15:0] CRC16_CCITT_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT    = 16'hFFFF;
    localparam logic [31:0] CRC32_POLY          = 32'h04C11DB7;

    // Frame state: IDLE = no frame open, RUN = frame open
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } crc_state_t;

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update over one data beat: Galois form, MSB of data first.
module crc_step #(
    parameter int unsigned      CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(8'h07),
    parameter int unsigned      DATA_W = 1
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] crc_acc;
    logic             fb;

    // Unrolled per-bit shift/xor, data[DATA_W-1] consumed first
    always_comb begin
        crc_acc = crc_in;
        fb      = 1'b0;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            fb      = crc_acc[CRC_W-1] ^ data[i];
            crc_acc = {crc_acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_out = crc_acc;
    end

endmodule

// File: rtl/crc_engine.sv
// Framed CRC generator/checker with sof/eof framing, valid stall, result strobe
// and residue pass/fail flag.
module crc_engine
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_POLY),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter int unsigned      DATA_W  = 1,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              sof,
    input  logic              eof,
    output logic              busy,
    output logic [CRC_W-1:0]  CRC_OUT,
    output logic              CRC_VALID,
    output logic              CRC_OK
);

    crc_state_t       state;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] step_in;
    logic [CRC_W-1:0] step_out;

    // A sof beat (or any beat while idle) starts from INIT; otherwise continue the open frame
    assign step_in = (state == RUN && !sof) ? crc_reg : INIT;

    crc_step #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_step (
        .crc_in  (step_in),
        .data    (din),
        .crc_out (step_out)
    );

    // busy is the registered state itself
    assign busy = (state == RUN);

    // Frame FSM, running CRC register and registered result outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            CRC_OUT   <= '0;
            CRC_VALID <= 1'b0;
            CRC_OK    <= 1'b0;
        end else begin
            CRC_VALID <= 1'b0;
            // Beats without sof while idle are dropped; a sof while running aborts silently
            if (din_valid && (sof || state == RUN)) begin
                if (eof) begin
                    CRC_OUT   <= step_out ^ XOROUT;
                    CRC_OK    <= (step_out == RESIDUE);
                    CRC_VALID <= 1'b1;
                    crc_reg   <= INIT;
                    state     <= IDLE;
                end else begin
                    crc_reg   <= step_out;
                    state     <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench: byte-wide and serial CRC-8 instances, scoreboard queues.
module tb_crc_engine;

    logic       CLK = 1'b0;
    logic       RST;

    logic [7:0] din8;
    logic       v8, sof8, eof8;
    logic       busy8, valid8, ok8;
    logic [7:0] out8;

    logic [0:0] din1;
    logic       v1, sof1, eof1;
    logic       busy1, valid1, ok1;
    logic [7:0] out1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] out;
        logic       ok;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_out;
        logic       exp_ok;
    } vec_t;

    typedef logic [7:0] frame_t [16];

    exp_t   q8[$];
    exp_t   q1[$];
    exp_t   e8, e1, x;
    int     nstrobe8 = 0;
    int     nstrobe1 = 0;
    int     strobe_cyc8[$];
    vec_t   vecs[5];
    frame_t f;
    int     base;
    int     busy_bad;
    logic [7:0] by;

    crc_engine #(
        .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .DATA_W(8), .RESIDUE(8'h00)
    ) u_byte (
        .CLK(CLK), .RST(RST), .din(din8), .din_valid(v8), .sof(sof8), .eof(eof8),
        .busy(busy8), .CRC_OUT(out8), .CRC_VALID(valid8), .CRC_OK(ok8)
    );

    crc_engine #(
        .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .DATA_W(1), .RESIDUE(8'h00)
    ) u_ser (
        .CLK(CLK), .RST(RST), .din(din1), .din_valid(v1), .sof(sof1), .eof(eof1),
        .busy(busy1), .CRC_OUT(out1), .CRC_VALID(valid1), .CRC_OK(ok1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-at-a-time reference CRC-8 (poly 0x07, init 0)
    function automatic logic [7:0] crc8_model(input frame_t fr, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ fr[i];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Scoreboard: every strobe must match the oldest pending expectation
    always @(negedge CLK) begin
        if (valid8 === 1'b1) begin
            nstrobe8++;
            strobe_cyc8.push_back(cyc);
            if (q8.size() == 0) begin
                check("unexpected_strobe8", 32'(valid8), 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("crc_out8", 32'(out8), 32'(e8.out));
                check("crc_ok8", 32'(ok8), 32'(e8.ok));
            end
        end
        if (valid1 === 1'b1) begin
            nstrobe1++;
            if (q1.size() == 0) begin
                check("unexpected_strobe1", 32'(valid1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("crc_out1", 32'(out1), 32'(e1.out));
                check("crc_ok1", 32'(ok1), 32'(e1.ok));
            end
        end
    end

    task automatic beat8(input logic [7:0] d, input logic s, input logic e);
        din8 = d; v8 = 1'b1; sof8 = s; eof8 = e;
        @(posedge CLK); #1;
        din8 = 8'h00; v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
    endtask

    task automatic send_frame8(input frame_t fr, input int n, input logic [7:0] exp_out,
                               input logic exp_ok);
        exp_t ex;
        ex.out = exp_out;
        ex.ok  = exp_ok;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) q8.push_back(ex);
            beat8(fr[i], i == 0, i == n - 1);
            if (i == 0 && n > 1) begin
                @(negedge CLK);
                check("busy8_after_sof", 32'(busy8), 32'd1);
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q8.size() != 0 || q1.size() != 0) && t < 20) begin
            @(negedge CLK);
            t++;
        end
        @(negedge CLK);
        check("scoreboard_drained", 32'(q8.size() + q1.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0;
        din8 = 8'h00; v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
        din1 = 1'b0;  v1 = 1'b0; sof1 = 1'b0; eof1 = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_out8", 32'(out8), 32'd0);
        check("reset_valid8", 32'(valid8), 32'd0);
        check("reset_ok8", 32'(ok8), 32'd0);
        check("reset_busy1", 32'(busy1), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;

        // Single-beat frames back to back
        vecs[0] = '{din: 8'h01, exp_out: 8'h07, exp_ok: 1'b0};
        vecs[1] = '{din: 8'h00, exp_out: 8'h00, exp_ok: 1'b1};
        vecs[2] = '{din: 8'h80, exp_out: 8'h89, exp_ok: 1'b0};
        vecs[3] = '{din: 8'hFF, exp_out: 8'hF3, exp_ok: 1'b0};
        vecs[4] = '{din: 8'h02, exp_out: 8'h0E, exp_ok: 1'b0};
        base = nstrobe8;
        for (int i = 0; i < 5; i++) begin
            x.out = vecs[i].exp_out;
            x.ok  = vecs[i].exp_ok;
            q8.push_back(x);
            beat8(vecs[i].din, 1'b1, 1'b1);
        end
        wait_drain();
        check("single_beat_strobes", 32'(nstrobe8 - base), 32'd5);
        if (strobe_cyc8.size() >= base + 5)
            check("single_beat_consecutive", 32'(strobe_cyc8[base+4] - strobe_cyc8[base]), 32'd4);
        check("single_beat_busy8", 32'(busy8), 32'd0);

        // CRC-8/SMBUS check string "123456789"
        for (int i = 0; i < 9; i++) f[i] = 8'(8'h31 + i);
        base = nstrobe8;
        send_frame8(f, 9, 8'hF4, 1'b0);
        wait_drain();
        check("check_frame_strobes", 32'(nstrobe8 - base), 32'd1);
        check("check_frame_busy_end", 32'(busy8), 32'd0);

        // Residue check with appended CRC, then a corrupted copy
        f[9] = 8'hF4;
        send_frame8(f, 10, 8'h00, 1'b1);
        f[4] = f[4] ^ 8'h01;
        send_frame8(f, 10, crc8_model(f, 10), 1'b0);
        wait_drain();
        f[4] = f[4] ^ 8'h01;

        // Abort an open frame with a new sof
        base = nstrobe8;
        beat8(8'hAA, 1'b1, 1'b0);
        beat8(8'h55, 1'b0, 1'b0);
        beat8(8'h12, 1'b0, 1'b0);
        beat8(8'hC3, 1'b0, 1'b0);
        send_frame8(f, 9, 8'hF4, 1'b0);
        wait_drain();
        check("abort_single_strobe", 32'(nstrobe8 - base), 32'd1);

        // Reset in the middle of a frame
        beat8(8'h31, 1'b1, 1'b0);
        beat8(8'h32, 1'b0, 1'b0);
        beat8(8'h33, 1'b0, 1'b0);
        beat8(8'h34, 1'b0, 1'b0);
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("midreset_busy8", 32'(busy8), 32'd0);
        check("midreset_valid8", 32'(valid8), 32'd0);
        check("midreset_out8", 32'(out8), 32'd0);
        check("midreset_ok8", 32'(ok8), 32'd0);
        base = nstrobe8;
        beat8(8'h10, 1'b0, 1'b1);
        beat8(8'h20, 1'b0, 1'b1);
        repeat (3) @(negedge CLK);
        check("eof_only_no_strobe", 32'(nstrobe8 - base), 32'd0);
        check("eof_only_busy8", 32'(busy8), 32'd0);

        // Serial frame, 72 bits MSB-first with random stalls
        base = nstrobe1;
        busy_bad = 0;
        x.out = 8'hF4;
        x.ok  = 1'b0;
        q1.push_back(x);
        for (int k = 0; k < 72; k++) begin
            while ($urandom_range(0, 2) == 0) begin
                v1 = 1'b0; sof1 = 1'($urandom); eof1 = 1'($urandom); din1 = 1'($urandom);
                @(posedge CLK); #1;
                if (k > 0) begin
                    @(negedge CLK);
                    if (busy1 !== 1'b1) busy_bad++;
                end
            end
            by   = f[k/8];
            din1 = by[7 - (k % 8)];
            v1   = 1'b1;
            sof1 = (k == 0);
            eof1 = (k == 71);
            @(posedge CLK); #1;
            v1 = 1'b0; sof1 = 1'b0; eof1 = 1'b0;
            if (k < 71) begin
                @(negedge CLK);
                if (busy1 !== 1'b1) busy_bad++;
            end
        end
        wait_drain();
        check("serial_busy_in_frame", 32'(busy_bad), 32'd0);
        check("serial_strobes", 32'(nstrobe1 - base), 32'd1);
        check("serial_busy_end", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
